// File: rtl/wb_stream_pkg.sv
// rtl/wb_stream_pkg.sv - shared constants and types for the stream-to-memory DMA writer
package wb_stream_pkg;

    // Register indices (byte address bits [4:2])
    localparam logic [2:0] REG_CSR   = 3'd0;
    localparam logic [2:0] REG_START = 3'd1;
    localparam logic [2:0] REG_BUF   = 3'd2;
    localparam logic [2:0] REG_BURST = 3'd3;
    localparam logic [2:0] REG_WRPTR = 3'd4;

    // CSR bit positions
    localparam int CSR_EN      = 0;
    localparam int CSR_IRQ     = 1;
    localparam int CSR_CIRC    = 2;
    localparam int CSR_HALF_IE = 3;
    localparam int CSR_ERR     = 4;
    localparam int CSR_BUSY    = 5;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_CHECK
    } dma_state_t;

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - synchronous word FIFO buffering the incoming stream
// Ports: i_data/i_push write side (push ignored when full), o_data/i_pop read side
// (o_data is the head word, pop ignored when empty), o_count/o_full/o_empty status.
module stream_fifo #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] i_data,
    input  logic          i_push,
    output logic [DW-1:0] o_data,
    input  logic          i_pop,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] r_mem [2**AW];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;
    // The count never exceeds the depth, so its MSB alone marks full.
    assign o_full  = r_count[AW];
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/wb_stream_dma_writer.sv
// rtl/wb_stream_dma_writer.sv - stream-to-memory DMA writer with Wishbone burst master and register slave
// Ports: clk/rst_n; wbm_* Wishbone master (write-only incrementing bursts);
// stream_s_* valid/ready input stream; irq_o level interrupt; wbs_* Wishbone register slave.
module wb_stream_dma_writer
    import wb_stream_pkg::*;
#(
    parameter int DW            = 32,
    parameter int AW            = 32,
    parameter int FIFO_AW       = 5,
    parameter int MAX_BURST_LEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic            wbm_we_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic [2:0]      wbm_cti_o,
    output logic [1:0]      wbm_bte_o,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic [DW-1:0]   stream_s_data_i,
    input  logic            stream_s_valid_i,
    output logic            stream_s_ready_o,
    output logic            irq_o,
    input  logic [4:0]      wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic            wbs_we_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic [2:0]      wbs_cti_i,
    input  logic [1:0]      wbs_bte_i,
    output logic [31:0]     wbs_dat_o,
    output logic            wbs_ack_o,
    output logic            wbs_err_o
);

    localparam int          WSB       = DW / 8;
    localparam int          LSB       = $clog2(WSB);
    localparam logic [31:0] WORD_MASK = ~(32'(WSB) - 32'd1);
    localparam logic [31:0] MAX_LEN   = 32'(MAX_BURST_LEN);

    dma_state_t r_state, w_next_state;

    logic        r_en, r_irq, r_circ, r_half_ie, r_err, r_busy;
    logic [31:0] r_start, r_buf, r_burst, r_ptr, r_rem, r_len, r_beat;
    logic        r_wbs_ack;
    logic [31:0] r_wbs_dat;

    logic             w_wbs_req, w_wr, w_csr_wr;
    logic [2:0]       w_idx;
    logic [31:0]      w_rdata, w_burst_wdata, w_burst_eff, w_len, w_half, w_ptr_next;
    logic             w_in_burst, w_ack, w_berr, w_last;
    logic             w_load, w_done, w_set_irq;
    logic [DW-1:0]    w_fifo_data;
    logic [FIFO_AW:0] w_fifo_count;
    logic             w_fifo_full, w_fifo_empty;
    logic             w_unused;

    assign w_unused = ^{wbm_dat_i, wbs_sel_i, wbs_cti_i, wbs_bte_i, wbs_adr_i[1:0], w_fifo_empty};

    stream_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (stream_s_data_i),
        .i_push  (stream_s_valid_i),
        .o_data  (w_fifo_data),
        .i_pop   (w_ack || w_berr),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Register slave: one-cycle registered ack; a held request re-arms only after ack drops.
    assign w_wbs_req = wbs_cyc_i && wbs_stb_i && !r_wbs_ack;
    assign w_wr      = w_wbs_req && wbs_we_i;
    assign w_idx     = wbs_adr_i[4:2];
    assign w_csr_wr  = w_wr && (w_idx == REG_CSR);

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            REG_CSR:   w_rdata = {26'd0, r_busy, r_err, r_half_ie, r_circ, r_irq, r_en};
            REG_START: w_rdata = r_start;
            REG_BUF:   w_rdata = r_buf;
            REG_BURST: w_rdata = r_burst;
            REG_WRPTR: w_rdata = r_ptr;
            default:   ;
        endcase
    end

    always_comb begin
        w_burst_wdata = wbs_dat_i;
        if (wbs_dat_i == 32'd0)      w_burst_wdata = 32'd1;
        else if (wbs_dat_i > MAX_LEN) w_burst_wdata = MAX_LEN;
    end

    // BURST_SIZE resets to 0; treat that as 1 so a start before programming it cannot hang.
    assign w_burst_eff = (r_burst == 32'd0) ? 32'd1 : r_burst;
    assign w_len       = (w_burst_eff < r_rem) ? w_burst_eff : r_rem;
    assign w_half      = (r_buf >> 1) & WORD_MASK;
    assign w_ptr_next  = r_ptr + 32'(WSB);
    assign w_in_burst  = (r_state == ST_BURST);
    assign w_berr      = w_in_burst && wbm_err_i;
    assign w_ack       = w_in_burst && wbm_ack_i && !wbm_err_i;
    assign w_last      = (r_beat == r_len - 32'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_done       = 1'b0;
        w_set_irq    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_csr_wr && wbs_dat_i[CSR_EN]) begin
                    if (r_buf != 32'd0) begin
                        w_load       = 1'b1;
                        w_next_state = ST_WAIT;
                    end else begin
                        w_set_irq = 1'b1;
                        w_done    = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Waiting for data is a burst boundary, so a stop request is honoured here too.
                if (!r_en) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (32'(w_fifo_count) >= w_len) begin
                    w_next_state = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_berr) begin
                    w_set_irq    = 1'b1;
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_ack) begin
                    if (r_half_ie && (w_ptr_next == w_half)) w_set_irq = 1'b1;
                    if (w_last) w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (r_rem == 32'd0) begin
                    w_set_irq = 1'b1;
                    if (r_circ && r_en) begin
                        w_load       = 1'b1;
                        w_next_state = ST_WAIT;
                    end else begin
                        w_done       = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end else if (r_en) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en      <= 1'b0;
            r_irq     <= 1'b0;
            r_circ    <= 1'b0;
            r_half_ie <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_start   <= '0;
            r_buf     <= '0;
            r_burst   <= '0;
            r_ptr     <= '0;
            r_rem     <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_wbs_ack <= 1'b0;
            r_wbs_dat <= '0;
        end else begin
            r_wbs_ack <= w_wbs_req;
            if (w_wbs_req) r_wbs_dat <= w_rdata;

            if (w_csr_wr) begin
                r_circ    <= wbs_dat_i[CSR_CIRC];
                r_half_ie <= wbs_dat_i[CSR_HALF_IE];
            end
            // EN is dropped whenever the engine returns to IDLE, so it reads as "transfer armed".
            if (w_done)        r_en <= 1'b0;
            else if (w_csr_wr) r_en <= wbs_dat_i[CSR_EN];
            // Hardware set beats a simultaneous W1C.
            if (w_set_irq)                           r_irq <= 1'b1;
            else if (w_csr_wr && wbs_dat_i[CSR_IRQ]) r_irq <= 1'b0;
            if (w_berr)                              r_err <= 1'b1;
            else if (w_csr_wr && wbs_dat_i[CSR_ERR]) r_err <= 1'b0;
            if (w_load)      r_busy <= 1'b1;
            else if (w_done) r_busy <= 1'b0;

            if (w_wr && !r_busy) begin
                case (w_idx)
                    REG_START: r_start <= wbs_dat_i & WORD_MASK;
                    REG_BUF:   r_buf   <= wbs_dat_i & WORD_MASK;
                    REG_BURST: r_burst <= w_burst_wdata;
                    default:   ;
                endcase
            end

            if (w_load) begin
                r_ptr <= '0;
                r_rem <= r_buf >> LSB;
            end else if (w_ack) begin
                r_ptr <= w_ptr_next;
                r_rem <= r_rem - 32'd1;
            end

            // r_len tracks the pending burst length while waiting; frozen once the burst starts.
            if (r_state == ST_WAIT) begin
                r_len  <= w_len;
                r_beat <= '0;
            end else if (w_ack) begin
                r_beat <= r_beat + 32'd1;
            end
        end
    end

    assign wbm_cyc_o        = w_in_burst;
    assign wbm_stb_o        = w_in_burst;
    assign wbm_we_o         = w_in_burst;
    assign wbm_adr_o        = w_in_burst ? (AW'(r_start) + AW'(r_ptr)) : '0;
    assign wbm_dat_o        = w_in_burst ? w_fifo_data : '0;
    assign wbm_sel_o        = '1;
    assign wbm_cti_o        = w_in_burst ? (w_last ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
    assign wbm_bte_o        = 2'b00;
    assign stream_s_ready_o = !w_fifo_full;
    assign irq_o            = r_irq;
    assign wbs_dat_o        = r_wbs_dat;
    assign wbs_ack_o        = r_wbs_ack;
    assign wbs_err_o        = 1'b0;

endmodule

// File: tb/tb_wb_stream_dma_writer.sv
// tb/tb_wb_stream_dma_writer.sv - scoreboard testbench for wb_stream_dma_writer
module tb_wb_stream_dma_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i, wbm_err_i;
    logic [31:0] stream_s_data_i;
    logic        stream_s_valid_i, stream_s_ready_o, irq_o;
    logic [4:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i, wbs_dat_o;
    logic        wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_ack_o, wbs_err_o;

    always #5 clk = ~clk;

    wb_stream_dma_writer #(.DW(32), .AW(32), .FIFO_AW(5), .MAX_BURST_LEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(32'd0),
        .stream_s_data_i(stream_s_data_i), .stream_s_valid_i(stream_s_valid_i),
        .stream_s_ready_o(stream_s_ready_o), .irq_o(irq_o),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(4'hF), .wbs_we_i(wbs_we_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_cti_i(3'd0), .wbs_bte_i(2'd0),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
    } beat_t;

    int          n_checks = 0;
    int          n_fail = 0;
    beat_t       exp_q[$];
    logic [31:0] stream_q[$];
    logic [31:0] mem [logic [31:0]];
    int          beat_cnt = 0;
    int          ack_dly_max = 0;
    int          err_at = -1;
    int          wait_cnt = 0;
    bit          err_pending = 1'b0;
    beat_t       mon_e;
    logic [31:0] rd;
    int          base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Stream source: presents the queue head; a word leaves the queue when ready is seen with it.
    initial begin
        stream_s_valid_i = 1'b0;
        stream_s_data_i  = '0;
        forever begin
            @(negedge clk);
            if (stream_q.size() > 0 && rst_n) begin
                stream_s_valid_i = 1'b1;
                stream_s_data_i  = stream_q[0];
                if (stream_s_ready_o) void'(stream_q.pop_front());
            end else begin
                stream_s_valid_i = 1'b0;
            end
        end
    end

    // Memory slave and monitor: each acked (or errored) beat is checked against the scoreboard.
    initial begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        forever begin
            @(negedge clk);
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            if (err_pending) begin
                check("cyc_after_err", {31'd0, wbm_cyc_o}, 32'd0);
                err_pending = 1'b0;
            end
            if (wbm_cyc_o && wbm_stb_o && rst_n) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got adr 0x%08h expected no beat", wbm_adr_o);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("beat_adr", wbm_adr_o, mon_e.adr);
                        check("beat_dat", wbm_dat_o, mon_e.dat);
                        check("beat_cti", 32'(wbm_cti_o), 32'(mon_e.cti));
                    end
                    if (beat_cnt == err_at) begin
                        wbm_err_i   = 1'b1;
                        err_pending = 1'b1;
                        err_at      = -1;
                    end else begin
                        wbm_ack_i = 1'b1;
                        mem[wbm_adr_o] = wbm_dat_o;
                    end
                    beat_cnt++;
                    wait_cnt = $urandom_range(ack_dly_max, 0);
                end
            end
        end
    end

    task automatic reg_access(input logic we, input logic [4:0] adr, input logic [31:0] wdat,
                              output logic [31:0] rdat);
        int t;
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = wdat;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!wbs_ack_o && t < 20);
        rdat = wbs_dat_o;
        check("wbs_ack_latency", 32'(t), 32'd1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic reg_write(input logic [4:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        reg_access(1'b1, adr, wdat, dummy);
    endtask

    task automatic reg_read(input logic [4:0] adr, output logic [31:0] rdat);
        reg_access(1'b0, adr, 32'd0, rdat);
    endtask

    task automatic wait_idle();
        logic [31:0] v;
        int t = 0;
        do begin
            reg_read(5'h00, v);
            t++;
        end while (v[5] && t < 500);
        check("busy_cleared", {31'd0, v[5]}, 32'd0);
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (beat_cnt < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("beats_reached", {31'd0, beat_cnt >= n}, 32'd1);
    endtask

    // Queue stream words plus the beats they must produce: bursts of min(burst, remaining).
    task automatic queue_transfer(input logic [31:0] start, input int words, input int burst,
                                  input logic [31:0] base_dat);
        beat_t b;
        int rem = words;
        int i = 0;
        int len;
        while (rem > 0) begin
            len = (burst < rem) ? burst : rem;
            for (int k = 0; k < len; k++) begin
                b.adr = start + 32'(4 * i);
                b.dat = base_dat + 32'(i);
                b.cti = (k == len - 1) ? 3'b111 : 3'b010;
                exp_q.push_back(b);
                stream_q.push_back(b.dat);
                i++;
            end
            rem -= len;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        stream_q.delete();
        err_at = -1;
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_adr_i = '0; wbs_dat_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and register boundaries
        check("reset_irq", {31'd0, irq_o}, 32'd0);
        check("reset_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        reg_read(5'h00, rd);  check("reset_csr", rd, 32'd0);
        reg_read(5'h0C, rd);  check("reset_burst", rd, 32'd0);
        reg_write(5'h0C, 32'd0);   reg_read(5'h0C, rd); check("burst_clamp_lo", rd, 32'd1);
        reg_write(5'h0C, 32'd100); reg_read(5'h0C, rd); check("burst_clamp_hi", rd, 32'd32);
        reg_write(5'h04, 32'h43);  reg_read(5'h04, rd); check("start_align", rd, 32'h40);
        reg_write(5'h08, 32'h63);  reg_read(5'h08, rd); check("buf_align", rd, 32'h60);
        reg_read(5'h14, rd);  check("unmapped_read", rd, 32'd0);

        // 1: three bursts of 8
        reg_write(5'h0C, 32'd8);
        queue_transfer(32'h40, 24, 8, 32'hA000_0000);
        reg_write(5'h00, 32'h01);
        wait_idle();
        check("t1_beats_left", 32'(exp_q.size()), 32'd0);
        check("t1_irq", {31'd0, irq_o}, 32'd1);
        reg_read(5'h00, rd);  check("t1_csr", rd & 32'h32, 32'h02);
        reg_read(5'h10, rd);  check("t1_wrptr", rd, 32'h60);
        check("t1_mem_first", mem[32'h40], 32'hA000_0000);
        check("t1_mem_last", mem[32'h9C], 32'hA000_0017);
        reg_write(5'h00, 32'h02);
        check("t1_irq_cleared", {31'd0, irq_o}, 32'd0);

        // Zero-size buffer: IRQ only
        reg_write(5'h08, 32'd0);
        reg_write(5'h00, 32'h01);
        check("zero_buf_irq", {31'd0, irq_o}, 32'd1);
        reg_read(5'h00, rd);  check("zero_buf_busy", rd & 32'h20, 32'd0);
        reg_write(5'h00, 32'h02);

        // 2: 10 words in bursts of 4, 4, 2
        reg_write(5'h04, 32'h100); reg_write(5'h08, 32'h28); reg_write(5'h0C, 32'd4);
        queue_transfer(32'h100, 10, 4, 32'hB000_0000);
        reg_write(5'h00, 32'h01);
        wait_idle();
        check("t2_beats_left", 32'(exp_q.size()), 32'd0);
        check("t2_tail_0", mem[32'h120], 32'hB000_0008);
        check("t2_tail_1", mem[32'h124], 32'hB000_0009);
        reg_read(5'h10, rd);  check("t2_wrptr", rd, 32'h28);
        reg_write(5'h00, 32'h02);

        // 3: single-beat bursts with random slave delay; config writes ignored while busy
        ack_dly_max = 5;
        reg_write(5'h04, 32'h180); reg_write(5'h08, 32'h20); reg_write(5'h0C, 32'd1);
        queue_transfer(32'h180, 8, 1, 32'h3000_0000);
        reg_write(5'h00, 32'h01);
        reg_write(5'h04, 32'hFFF0);
        wait_idle();
        ack_dly_max = 0;
        check("t3_beats_left", 32'(exp_q.size()), 32'd0);
        reg_read(5'h04, rd);  check("t3_start_locked", rd, 32'h180);
        reg_write(5'h00, 32'h02);

        // 5: bus error on beat 3 of 8
        reg_write(5'h04, 32'h400); reg_write(5'h0C, 32'd8);
        queue_transfer(32'h400, 8, 8, 32'h5000_0000);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        err_at = beat_cnt + 3;
        reg_write(5'h00, 32'h01);
        wait_idle();
        check("t5_beats_left", 32'(exp_q.size()), 32'd0);
        check("t5_irq", {31'd0, irq_o}, 32'd1);
        reg_read(5'h00, rd);  check("t5_csr_err", rd & 32'h32, 32'h12);
        reg_read(5'h10, rd);  check("t5_wrptr", rd, 32'h0C);
        reg_write(5'h00, 32'h12);
        reg_read(5'h00, rd);  check("t5_csr_cleared", rd & 32'h32, 32'h00);
        check("t5_irq_cleared", {31'd0, irq_o}, 32'd0);
        do_reset();

        // 4: ring mode with half-buffer IRQ, wrap, overwrite, stop at burst boundary
        reg_write(5'h04, 32'h200); reg_write(5'h08, 32'h40); reg_write(5'h0C, 32'd8);
        base = beat_cnt;
        queue_transfer(32'h200, 8, 8, 32'hC000_0000);
        reg_write(5'h00, 32'h0D);
        wait_beats(base + 8);
        repeat (3) @(negedge clk);
        check("t4_half_irq", {31'd0, irq_o}, 32'd1);
        reg_read(5'h10, rd);  check("t4_half_wrptr", rd, 32'h20);
        reg_read(5'h00, rd);  check("t4_busy", rd & 32'h20, 32'h20);
        reg_write(5'h00, 32'h0F);
        check("t4_irq_cleared", {31'd0, irq_o}, 32'd0);
        queue_transfer(32'h220, 8, 8, 32'hC000_0008);
        wait_beats(base + 16);
        repeat (3) @(negedge clk);
        check("t4_wrap_irq", {31'd0, irq_o}, 32'd1);
        reg_read(5'h10, rd);  check("t4_wrap_wrptr", rd, 32'h00);
        reg_write(5'h00, 32'h0F);
        ack_dly_max = 3;
        queue_transfer(32'h200, 8, 8, 32'hD000_0000);
        for (int i = 0; i < 8; i++) stream_q.push_back(32'hDEAD_0000 + 32'(i));
        wait_beats(base + 17);
        reg_write(5'h00, 32'h0C);
        wait_idle();
        ack_dly_max = 0;
        check("t4_beats_left", 32'(exp_q.size()), 32'd0);
        check("t4_overwrite_0", mem[32'h200], 32'hD000_0000);
        check("t4_overwrite_7", mem[32'h21C], 32'hD000_0007);
        check("t4_second_half", mem[32'h220], 32'hC000_0008);
        reg_read(5'h10, rd);  check("t4_stop_wrptr", rd, 32'h20);
        do_reset();

        // 6: reset in the middle of a burst
        reg_write(5'h04, 32'h300); reg_write(5'h08, 32'h20); reg_write(5'h0C, 32'd8);
        base = beat_cnt;
        queue_transfer(32'h300, 8, 8, 32'hE000_0000);
        reg_write(5'h00, 32'h09);
        wait_beats(base + 6);
        check("t6_pre_reset_irq", {31'd0, irq_o}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_cyc_low", {31'd0, wbm_cyc_o}, 32'd0);
        check("t6_stb_low", {31'd0, wbm_stb_o}, 32'd0);
        check("t6_irq_low", {31'd0, irq_o}, 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        stream_q.delete();
        for (int a = 0; a < 5; a++) begin
            reg_read(5'(a * 4), rd);
            check("t6_reg_zero", rd, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
